// File: rtl/hazard_forwarding_ctrl.sv
// Hazard unit beside the ID stage: per-operand EX/MEM forwarding selects registered into EX,
// load-use stall/bubble generation with a LOAD_LAT-cycle FSM, and a saturating stall counter.
module hazard_forwarding_ctrl #(
    parameter int NB_REG   = 5,
    parameter int NB_MUX   = 2,
    parameter int N_SRC    = 2,
    parameter int LOAD_LAT = 1,
    parameter int NB_CNT   = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic                      i_flush,
    input  logic [N_SRC*NB_REG-1:0]   i_ID_src,
    input  logic [NB_REG-1:0]         i_EX_rd,
    input  logic                      i_EX_write_reg,
    input  logic                      i_EX_mem_read,
    input  logic [NB_REG-1:0]         i_MEM_rd,
    input  logic                      i_MEM_write_reg,
    output logic [N_SRC*NB_MUX-1:0]   o_forwarding,
    output logic                      o_stall_pc,
    output logic                      o_stall_if_id,
    output logic                      o_bubble_id_ex,
    output logic [NB_CNT-1:0]         o_stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [NB_MUX-1:0] SEL_RF  = NB_MUX'(0);
    localparam logic [NB_MUX-1:0] SEL_EX  = NB_MUX'(1);
    localparam logic [NB_MUX-1:0] SEL_MEM = NB_MUX'(2);
    // Remaining STALL-state cycles after the detect cycle, minus one.
    localparam logic [1:0] BUB_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_t                    state_q, state_d;
    logic [1:0]                bub_q, bub_d;
    logic [N_SRC*NB_MUX-1:0]   fwd_q, fwd_d;
    logic [NB_CNT-1:0]         cnt_q, cnt_d;
    logic [N_SRC*NB_MUX-1:0]   fwd_nxt_s;
    logic [N_SRC-1:0]          ld_hit_s;
    logic                      hazard_s;
    logic                      stall_s;
    logic                      stall_out_s;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        logic [NB_REG-1:0] src_s;
        logic              nz_s;
        logic              ex_hit_s;
        logic              mem_hit_s;

        assign src_s     = i_ID_src[k*NB_REG +: NB_REG];
        assign nz_s      = (src_s != NB_REG'(0));
        assign ex_hit_s  = nz_s && (src_s == i_EX_rd) && i_EX_write_reg && !i_EX_mem_read;
        assign mem_hit_s = nz_s && (src_s == i_MEM_rd) && i_MEM_write_reg;
        assign ld_hit_s[k] = nz_s && (src_s == i_EX_rd);
        assign fwd_nxt_s[k*NB_MUX +: NB_MUX] = ex_hit_s  ? SEL_EX  :
                                               mem_hit_s ? SEL_MEM : SEL_RF;
    end

    assign hazard_s    = (state_q == IDLE) && i_EX_mem_read && i_EX_write_reg && (|ld_hit_s);
    assign stall_s     = hazard_s || (state_q == STALL);
    // Flush aborts the stall in the same cycle; reset forces the stall lines low.
    assign stall_out_s = stall_s && !i_flush && i_reset_n;

    assign o_stall_pc     = stall_out_s;
    assign o_stall_if_id  = stall_out_s;
    assign o_bubble_id_ex = stall_out_s;
    assign o_forwarding   = fwd_q;
    assign o_stall_cnt    = cnt_q;

    // Bubble FSM next state; frozen while disabled, flush returns to IDLE.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        if (!i_enable) begin
            state_d = state_q;
            bub_d   = bub_q;
        end else if (i_flush) begin
            state_d = IDLE;
            bub_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hazard_s && (LOAD_LAT > 1)) begin
                        state_d = STALL;
                        bub_d   = BUB_INIT;
                    end else begin
                        state_d = IDLE;
                        bub_d   = bub_q;
                    end
                end
                STALL: begin
                    if (bub_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        bub_d = bub_q - 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    bub_d   = 2'd0;
                end
            endcase
        end
    end

    // Forwarding selects and saturating stall counter next state.
    always_comb begin
        fwd_d = fwd_q;
        cnt_d = cnt_q;
        if (!i_enable) begin
            fwd_d = fwd_q;
        end else if (i_flush || stall_s) begin
            fwd_d = '0;
        end else begin
            fwd_d = fwd_nxt_s;
        end
        if (i_enable && stall_s && !i_flush && (cnt_q != {NB_CNT{1'b1}})) begin
            cnt_d = cnt_q + NB_CNT'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            bub_q   <= 2'd0;
            fwd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            fwd_q   <= fwd_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
